// File: rtl/rd_port_arbiter.sv
// rtl/rd_port_arbiter.sv - round-robin burst scheduler sharing one async-FIFO read port among NREQ consumers
module rd_port_arbiter #(
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             arb_en,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    input  logic [NREQ-1:0]  oready,
    output logic [DSIZE-1:0] odata,
    output logic             ovalid,
    output logic             olast
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAXBURST + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MAXBURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [NREQ-1:0]   gnt_q;
    logic [IW-1:0]     idx_q;
    logic [IW-1:0]     rr_q;
    logic [CW-1:0]     cnt_q;
    logic [DSIZE-1:0]  odata_q;
    logic              ovalid_q;
    logic              olast_q;

    logic              pop;
    logic              win_found;
    logic [IW-1:0]     win_idx;
    logic [IW:0]       cand_sum;

    // A word leaves the FIFO only while bursting, the owner still wants data,
    // the FIFO has something, and the output register is free or being emptied.
    always_comb begin
        pop = (state_q == BURST) && req[idx_q] && !rempty && (!ovalid_q || oready[idx_q]);
    end

    // Round-robin search: first requester after the previous winner, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = {1'b0, rr_q} + (IW+1)'(k);
            if (cand_sum >= (IW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IW+1)'(NREQ);
            end
            if (!win_found && req[cand_sum[IW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_sum[IW-1:0];
            end
        end
    end

    // Scheduler FSM with registered grant and output stage; reset drops any held word.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            idx_q    <= '0;
            rr_q     <= IW'(NREQ - 1);
            cnt_q    <= '0;
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            olast_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    gnt_q <= '0;
                    if (arb_en && win_found) begin
                        gnt_q   <= NREQ'(1) << win_idx;
                        idx_q   <= win_idx;
                        rr_q    <= win_idx;
                        cnt_q   <= '0;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (pop) begin
                        odata_q  <= rdata;
                        ovalid_q <= 1'b1;
                        cnt_q    <= cnt_q + CW'(1);
                        olast_q  <= (cnt_q == LAST_CNT);
                        if (cnt_q == LAST_CNT) begin
                            state_q <= DRAIN;
                        end
                    end else begin
                        if (ovalid_q && oready[idx_q]) begin
                            ovalid_q <= 1'b0;
                            olast_q  <= 1'b0;
                        end
                        if (!req[idx_q]) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!ovalid_q || oready[idx_q]) begin
                        ovalid_q <= 1'b0;
                        olast_q  <= 1'b0;
                        gnt_q    <= '0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign rinc   = pop;
    assign gnt    = gnt_q;
    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign olast  = olast_q;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// tb/tb_rd_port_arbiter.sv - self-checking bench for rd_port_arbiter
module tb_rd_port_arbiter;

    logic       rclk = 1'b0;
    logic       rrst_n;
    logic       rempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       arb_en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] oready;
    logic [7:0] odata;
    logic       ovalid;
    logic       olast;

    rd_port_arbiter #(.DSIZE(8), .NREQ(4), .MAXBURST(8)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rempty (rempty),
        .rdata  (rdata),
        .rinc   (rinc),
        .arb_en (arb_en),
        .req    (req),
        .gnt    (gnt),
        .oready (oready),
        .odata  (odata),
        .ovalid (ovalid),
        .olast  (olast)
    );

    always #5 rclk = ~rclk;

    // FIFO model: circular memory, writes from the stimulus, pops on rinc
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] wr_val = 8'h30;
    int         cyc = 0;
    int         pop_n = 0;
    int         pop_cyc [0:1023];

    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[7:0]];

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (rinc) begin
            rd_ptr         <= rd_ptr + 1;
            pop_cyc[pop_n] <= cyc;
            pop_n          <= pop_n + 1;
        end
    end

    // Consumer-side monitor, sampled mid-cycle
    int         xfer_n = 0;
    int         x_idx  [0:1023];
    logic [7:0] x_data [0:1023];
    logic       x_last [0:1023];
    int         g_n = 0;
    logic [3:0] g_log  [0:255];
    logic [3:0] prev_gnt = 4'b0;
    int         viol_empty = 0;
    int         viol_bp = 0;
    int         viol_oh = 0;

    function automatic int idx_of(input logic [3:0] g);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = i;
        end
        return r;
    endfunction

    always @(negedge rclk) begin
        prev_gnt <= gnt;
        if (rrst_n && ovalid && ((gnt & oready) != 4'b0)) begin
            x_idx[xfer_n]  <= idx_of(gnt);
            x_data[xfer_n] <= odata;
            x_last[xfer_n] <= olast;
            xfer_n         <= xfer_n + 1;
        end
        if (gnt != 4'b0 && prev_gnt == 4'b0) begin
            g_log[g_n] <= gnt;
            g_n        <= g_n + 1;
        end
        if (rinc && rempty) viol_empty <= viol_empty + 1;
        if (rinc && ovalid && ((gnt & oready) == 4'b0)) viol_bp <= viol_bp + 1;
        if ((gnt & (gnt - 4'd1)) != 4'b0) viol_oh <= viol_oh + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = wr_val;
            wr_ptr = wr_ptr + 1;
            wr_val = wr_val + 8'd1;
        end
    endtask

    task automatic do_reset();
        req    = 4'b0;
        arb_en = 1'b0;
        oready = 4'b1111;
        rrst_n = 1'b0;
        #3;
        wr_ptr = rd_ptr;
        rrst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name, input int max);
        int n;
        n = 0;
        while (gnt != 4'b0 && n < max) begin
            tick();
            n++;
        end
        check(name, {31'b0, gnt == 4'b0}, 32'd1);
    endtask

    task automatic check_burst(input string name, input int x0, input int cnt, input int idx,
                               input logic [7:0] first, input int full);
        for (int k = 0; k < cnt; k++) begin
            check({name, "_idx"},  x_idx[x0+k], idx);
            check({name, "_data"}, x_data[x0+k], 8'(first + 8'(k)));
            check({name, "_last"}, x_last[x0+k], (full != 0 && k == cnt - 1) ? 1 : 0);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic       en;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t       vecs [0:6];
    logic [3:0] pat;
    logic [7:0] first;
    int         x0, p0, g0, t, ve, vb;

    initial begin
        vecs[0] = '{4'b0000, 1'b1, 4'b0000};
        vecs[1] = '{4'b0001, 1'b1, 4'b0001};
        vecs[2] = '{4'b0110, 1'b1, 4'b0010};
        vecs[3] = '{4'b1000, 1'b1, 4'b1000};
        vecs[4] = '{4'b1111, 1'b0, 4'b0000};
        vecs[5] = '{4'b1100, 1'b1, 4'b0100};
        vecs[6] = '{4'b1010, 1'b1, 4'b0010};

        // reset state
        req = 4'b0; arb_en = 1'b0; oready = 4'b1111; rrst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_ovalid", ovalid, 0);
        check("rst_olast", olast, 0);
        check("rst_odata", odata, 0);
        check("rst_rinc", rinc, 0);
        #3;

        // first grant from reset: lowest set req wins, arb_en gates
        for (int v = 0; v < 7; v++) begin
            do_reset();
            req    = vecs[v].req;
            arb_en = vecs[v].en;
            tick();
            check($sformatf("vec%0d_gnt", v), gnt, vecs[v].exp_gnt);
            check($sformatf("vec%0d_rinc", v), rinc, 0);
        end

        // single burst of 8 from a 10-word FIFO
        do_reset();
        first = wr_val; x0 = xfer_n; p0 = pop_n;
        load(10);
        req = 4'b0001; arb_en = 1'b1;
        tick();
        check("single_gnt", gnt, 4'b0001);
        wait_idle("single_done", 40);
        req = 4'b0; arb_en = 1'b0;
        tick();
        check("single_count", xfer_n - x0, 8);
        check_burst("single", x0, 8, 0, first, 1);
        check("single_b2b", pop_cyc[p0+7] - pop_cyc[p0], 7);
        check("single_left", wr_ptr - rd_ptr, 2);

        // round robin with all requesting
        do_reset();
        first = wr_val; x0 = xfer_n; p0 = pop_n; g0 = g_n;
        load(60);
        req = 4'b1111; arb_en = 1'b1;
        t = 0;
        while (g_n - g0 < 5 && t < 300) begin
            tick();
            t++;
        end
        check("rr_grants_seen", {31'b0, g_n - g0 >= 5}, 32'd1);
        req = 4'b0; arb_en = 1'b0;
        wait_idle("rr_done", 40);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("rr_order%0d", j), g_log[g0+j], 4'b0001 << (j % 4));
        end
        for (int b = 0; b < 4; b++) begin
            check_burst($sformatf("rr_b%0d", b), x0 + 8*b, 8, b, 8'(first + 8'(8*b)), 1);
        end
        check("rr_gap", pop_cyc[p0+8] - pop_cyc[p0+7], 3);

        // FIFO runs empty mid-burst
        do_reset();
        first = wr_val; x0 = xfer_n; p0 = pop_n; ve = viol_empty;
        load(3);
        req = 4'b0010; arb_en = 1'b1;
        t = 0;
        while (pop_n - p0 < 3 && t < 20) begin
            tick();
            t++;
        end
        check("empty_first3", pop_n - p0, 3);
        for (int i = 0; i < 5; i++) tick();
        check("empty_gnt_held", gnt, 4'b0010);
        check("empty_no_pop", pop_n - p0, 3);
        load(5);
        wait_idle("empty_done", 40);
        req = 4'b0; arb_en = 1'b0;
        tick();
        check("empty_count", xfer_n - x0, 8);
        check_burst("empty", x0, 8, 1, first, 1);
        check("empty_rinc_viol", viol_empty - ve, 0);

        // back-pressure pattern on consumer 0
        do_reset();
        first = wr_val; x0 = xfer_n; vb = viol_bp;
        load(10);
        pat = 4'b1001;
        req = 4'b0001; arb_en = 1'b1;
        for (t = 0; t < 200; t++) begin
            oready = {3'b111, pat[t % 4]};
            tick();
            if (t > 0 && gnt == 4'b0) break;
        end
        check("bp_done", gnt, 0);
        req = 4'b0; arb_en = 1'b0; oready = 4'b1111;
        tick();
        check("bp_count", xfer_n - x0, 8);
        check_burst("bp", x0, 8, 0, first, 1);
        check("bp_rinc_viol", viol_bp - vb, 0);
        check("bp_left", wr_ptr - rd_ptr, 2);

        // early release after 3 words, then arb_en blocks a new grant
        do_reset();
        first = wr_val; x0 = xfer_n; p0 = pop_n;
        load(10);
        req = 4'b0100; arb_en = 1'b1;
        t = 0;
        while (pop_n - p0 < 3 && t < 20) begin
            tick();
            t++;
        end
        req = 4'b0001; arb_en = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("early_gnt_blocked", gnt, 0);
        check("early_count", xfer_n - x0, 3);
        check_burst("early", x0, 3, 2, first, 0);
        check("early_left", wr_ptr - rd_ptr, 7);

        // asynchronous reset in the middle of a burst
        do_reset();
        load(10);
        req = 4'b0001; arb_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("midrst_pre_ovalid", ovalid, 1);
        #2;
        rrst_n = 1'b0;
        #1;
        check("midrst_gnt", gnt, 0);
        check("midrst_ovalid", ovalid, 0);
        check("midrst_olast", olast, 0);
        check("midrst_rinc", rinc, 0);
        check("midrst_odata", odata, 0);
        req = 4'b0; arb_en = 1'b0;
        #3;
        rrst_n = 1'b1;
        tick();

        check("onehot_viol", viol_oh, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
